// File: rtl/cnn_layer_accel_weight_seq_ctrl_if.sv
// Handshake bundle between the weight sequencer and the weight-fetch stage.
// The sequencer presents table selection values; the consumer answers with seq_rdy.
interface cnn_layer_accel_weight_seq_ctrl_if;
   logic       seq_valid;
   logic       seq_rdy;
   logic [1:0] gray_code;
   logic       sequence_selector;
   logic [2:0] seq_data_addr;

   modport master (
      output seq_valid,
      output gray_code,
      output sequence_selector,
      output seq_data_addr,
      input  seq_rdy
   );

   modport slave (
      input  seq_valid,
      input  gray_code,
      input  sequence_selector,
      input  seq_data_addr,
      output seq_rdy
   );
endinterface

// File: rtl/cnn_layer_accel_weight_seq_ctrl.sv
// QUAD weight sequence table driver: walks entries per column, toggles selector per column, gray code per row.
// Optional stall counter output perf_stall_cnt is enabled by defining CNN_LAYER_ACCEL_WSEQ_PERF_EN.
module cnn_layer_accel_weight_seq_ctrl #(
   parameter int C_COL_W   = 10,
   parameter int C_ROW_W   = 10,
   parameter int C_SEQ_LEN = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   input  logic [C_COL_W-1:0]   cfg_num_cols,
   input  logic [C_ROW_W-1:0]   cfg_num_rows,
   cnn_layer_accel_weight_seq_ctrl_if.master seq,
   output logic                 busy,
   output logic                 done
`ifdef CNN_LAYER_ACCEL_WSEQ_PERF_EN
   ,
   output logic [31:0]          perf_stall_cnt
`endif
);

   localparam logic [2:0] LAST_ADDR = 3'(C_SEQ_LEN - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t               state;
   state_t               next_state;
   logic [2:0]           addr_q;
   logic                 sel_q;
   logic [1:0]           gray_q;
   logic [C_COL_W-1:0]   col_cnt;
   logic [C_ROW_W-1:0]   row_cnt;
   logic [C_COL_W-1:0]   num_cols_q;
   logic [C_ROW_W-1:0]   num_rows_q;

   logic cfg_ok;
   logic take_start;
   logic beat;
   logic end_col;
   logic end_row;
   logic last_beat;

   assign cfg_ok     = (|cfg_num_cols) && (|cfg_num_rows);
   assign take_start = (state == S_IDLE) && start && !abort;
   assign beat       = (state == S_RUN) && seq.seq_rdy && !abort;
   assign end_col    = (addr_q == LAST_ADDR);
   assign end_row    = end_col && (col_cnt == num_cols_q - C_COL_W'(1));
   assign last_beat  = end_row && (row_cnt == num_rows_q - C_ROW_W'(1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: begin
            if (take_start) begin
               next_state = cfg_ok ? S_RUN : S_DONE;
            end
         end
         S_RUN: begin
            if (abort) begin
               next_state = S_IDLE;
            end else if (beat && last_beat) begin
               next_state = S_DONE;
            end
         end
         S_DONE: begin
            next_state = S_IDLE;
         end
         default: begin
            next_state = S_IDLE;
         end
      endcase
   end

   always_comb begin
      seq.seq_valid         = (state == S_RUN);
      seq.gray_code         = gray_q;
      seq.sequence_selector = sel_q;
      seq.seq_data_addr     = addr_q;
      busy                  = (state != S_IDLE);
      done                  = (state == S_DONE);
   end

   // The final beat leaves the position untouched; DONE and abort both park it at the idle values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q     <= '0;
         sel_q      <= 1'b1;
         gray_q     <= 2'b00;
         col_cnt    <= '0;
         row_cnt    <= '0;
         num_cols_q <= '0;
         num_rows_q <= '0;
      end else if (take_start) begin
         num_cols_q <= cfg_num_cols;
         num_rows_q <= cfg_num_rows;
         addr_q     <= '0;
         sel_q      <= 1'b1;
         gray_q     <= 2'b00;
         col_cnt    <= '0;
         row_cnt    <= '0;
      end else if (((state == S_RUN) && abort) || (state == S_DONE)) begin
         addr_q     <= '0;
         sel_q      <= 1'b1;
         gray_q     <= 2'b00;
         col_cnt    <= '0;
         row_cnt    <= '0;
      end else if (beat && !last_beat) begin
         if (!end_col) begin
            addr_q <= addr_q + 3'd1;
         end else begin
            addr_q <= '0;
            if (end_row) begin
               col_cnt <= '0;
               sel_q   <= 1'b1;
               row_cnt <= row_cnt + C_ROW_W'(1);
               gray_q  <= {gray_q[0], ~gray_q[1]};
            end else begin
               col_cnt <= col_cnt + C_COL_W'(1);
               sel_q   <= ~sel_q;
            end
         end
      end
   end

`ifdef CNN_LAYER_ACCEL_WSEQ_PERF_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_stall_cnt <= '0;
      end else if (take_start) begin
         perf_stall_cnt <= '0;
      end else if ((state == S_RUN) && !seq.seq_rdy && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
         perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: doc/cnn_layer_accel_weight_seq_ctrl.md
Name: cnn_layer_accel_weight_seq_ctrl

Overview:
- Sequencer that drives the QUAD weight sequence table's selection inputs: `gray_code`, `sequence_selector` and `seq_data_addr`.
- Walks a 5-entry weight sequence once per output column and alternates the selector every column.
- Advances the 2-bit Gray code once per output row, and terminates after a configured number of rows.
- Sits between the QUAD control FSM (`start`, `abort`, configuration) and the weight table, with a valid/ready handshake toward the consuming weight-fetch stage.

Parameters:
- `C_COL_W`, 10, width of the column-count configuration.
- `C_ROW_W`, 10, width of the row-count configuration.
- `C_SEQ_LEN`, 5, entries per weight sequence; `seq_data_addr` runs 0..C_SEQ_LEN-1. Legal range 1..8.

Ports:
- `clk`  input  1  single clock; all logic is rising-edge.
- `rst`  input  1  asynchronous, active-low reset.
- `start`  input  1  one-cycle pulse; begins a pass. Honoured only in IDLE.
- `abort`  input  1  synchronous cancel; returns to IDLE.
- `cfg_num_cols`  input  C_COL_W  output columns per row; sampled at start.
- `cfg_num_rows`  input  C_ROW_W  output rows per pass; sampled at start.
- `seq_rdy`  input  1  consumer ready.
- `seq_valid`  output  1  gray_code/sequence_selector/seq_data_addr are valid.
- `gray_code`  output  2  row phase.
- `sequence_selector`  output  1  column parity select.
- `seq_data_addr`  output  3  sequence entry index.
- `busy`  output  1  high in RUN and DONE.
- `done`  output  1  one-cycle pulse at end of pass.

Behaviour:
- Reset (`rst`=0, asynchronous) values:
  - state=IDLE; `seq_valid`=0, `gray_code`=2'b00, `sequence_selector`=1, `seq_data_addr`=0, `busy`=0, `done`=0.
  - All counters and latched configuration are cleared.
  - Reset asserted mid-pass discards the pass; no `done` is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - `start`=1 with both configs nonzero: latch configs, zero the column and row counters, go to RUN next cycle.
  - `start`=1 with either config zero: go to DONE with no beats issued.
- RUN:
  - `seq_valid`=1. A beat completes on `seq_valid` & `seq_rdy`.
  - Outputs hold while `seq_rdy`=0.
  - First beat of a pass presents addr=0, selector=1, gray=00; it appears the cycle after `start` (1-cycle latency).
- Beat advance, applied on each completed beat:
  - If addr < C_SEQ_LEN-1: addr+1.
  - Else (end of column): addr=0, selector toggles, column counter+1.
  - End of row (column counter reaches cfg_num_cols-1 at end of column): column counter=0, selector reloads to 1, row counter+1, `gray_code` advances in the order 00→01→11→10→00 (wraps).
  - Final beat (last addr, last column, last row): go to DONE; `seq_valid` drops the next cycle.
- DONE:
  - Lasts exactly one cycle with `done`=1 and `busy`=1, then IDLE.
  - `gray_code` and `sequence_selector` return to 00 and 1 on entry to IDLE.
- `start` outside IDLE is ignored.
- `abort`:
  - From RUN or DONE: go to IDLE next cycle, `seq_valid`=0, no `done` pulse.
  - Takes priority over a simultaneous handshake; that beat is not counted as advancing.
  - In IDLE it overrides a simultaneous `start`.
- Configuration inputs are don't-care outside the `start` cycle.
- Counters are compared, never wrapped; maximum config values (all-ones) are legal.

Optional Feature:
- Macro: `CNN_LAYER_ACCEL_WSEQ_PERF_EN`.
- Defined:
  - Adds output `perf_stall_cnt` [31:0], which counts cycles in RUN with `seq_valid`=1 and `seq_rdy`=0.
  - Clears on `start` acceptance and on reset; holds its value in IDLE; saturates at all-ones.
- Not defined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Basic pass:
  - Stimulus: cols=2, rows=1, `seq_rdy`=1, `start` pulse.
  - Response: 10 beats, addr 0..4 with selector=1, then addr 0..4 with selector=0; gray=00 throughout; `done` on cycle start+11; `busy` high cycles start+1..start+11.
- Gray walk:
  - Stimulus: cols=1, rows=5.
  - Response: gray sequence per row 00,01,11,10,00; selector=1 on every row; 25 beats; one `done` pulse.
- Backpressure:
  - Stimulus: cols=1, rows=1; `seq_rdy` low for 3 cycles at addr=2.
  - Response: outputs frozen at addr=2 for those cycles; total 5 beats; with `CNN_LAYER_ACCEL_WSEQ_PERF_EN` defined, `perf_stall_cnt`=3.
- Zero config:
  - Stimulus: cols=0, rows=4, `start`.
  - Response: `seq_valid` never asserts; `done` on cycle start+1.
- Abort:
  - Stimulus: `abort` asserted together with a handshake at beat 7 of a cols=2, rows=2 pass.
  - Response: IDLE next cycle; no `done`; `gray_code`=00, `sequence_selector`=1; a following `start` restarts from addr=0.
- Async reset:
  - Stimulus: drop `rst` mid-RUN, between clock edges.
  - Response: outputs reach reset values immediately without waiting for a clock edge; `start` is ignored while `rst`=0.
